regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- Arbitrates between two write-back requesters: req0 (ALU/single-cycle path) and req1 (load/multi-cycle path), using a valid/ready handshake.
- Registers the granted write onto the register-file port.
- Keeps a pending-write scoreboard so issue logic can stall on RAW/WAW hazards until the write is visible through the register file's asynchronous read.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W.
- FIXED_PRIO, 0, 0 = round-robin between req0/req1; 1 = req0 always wins.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-low.
- req0_valid  in  1  ALU write-back request.
- req0_ready  out  1  req0 granted this cycle.
- req0_rd  in  ADDR_W  destination register.
- req0_data  in  DATA_W  write data.
- req1_valid  in  1  load write-back request.
- req1_ready  out  1  req1 granted this cycle.
- req1_rd  in  ADDR_W  destination register.
- req1_data  in  DATA_W  write data.
- rf_write_enable  out  1  to register file write_enable.
- rf_write_reg  out  ADDR_W  to register file write_reg.
- rf_write_data  out  DATA_W  to register file write_data.
- sb_set  in  1  issue of an instruction that writes sb_rd.
- sb_rd  in  ADDR_W  destination of issuing instruction.
- rs1  in  ADDR_W  source 1 of instruction at issue.
- rs2  in  ADDR_W  source 2 of instruction at issue.
- rs1_busy  out  1  pending write to rs1.
- rs2_busy  out  1  pending write to rs2.
- issue_stall  out  1  rs1_busy | rs2_busy | pending[sb_rd] (WAW).

Behaviour:
- Reset (rst==0 at a rising edge):
  - rf_write_enable=0, rf_write_reg=0, rf_write_data=0.
  - All pending bits cleared.
  - last_grant=1, so req0 wins the first contention.
  - Any in-flight granted write is discarded.
  - Ready outputs are combinational and forced to 0 while rst==0.
- Arbitration (combinational, one grant per cycle, no downstream backpressure):
  - Only one valid: that requester is granted.
  - Both valid, FIXED_PRIO=1: req0 granted.
  - Both valid, FIXED_PRIO=0: the requester not equal to last_grant is granted.
  - last_grant updates only on a cycle with a grant.
  - reqX_ready = grant to X; never both high. reqX_ready depends on the other requester's valid but not on its own data.
  - A transfer occurs at an edge where valid&&ready. Requesters hold valid/rd/data stable until the transfer.
- Write stage (latency 1):
  - A transfer at edge N drives rf_write_enable=1 with the captured rd/data during cycle N+1.
  - The register file commits at edge N+1.
  - No transfer: rf_write_enable=0 the next cycle; rf_write_reg/rf_write_data hold their previous values.
- x0 handling:
  - A request with rd==0 is still handshaked (ready asserted), but produces rf_write_enable=0.
  - sb_set with sb_rd==0 sets nothing.
  - rs1/rs2==0 never report busy.
- Scoreboard (NUM_REGS bits):
  - pending[sb_rd] is set at the edge where sb_set==1 && sb_rd!=0.
  - pending[r] is cleared at the edge where rf_write_enable==1 && rf_write_reg==r, i.e. the same edge the register file commits. From the next cycle the asynchronous read returns new data and busy is low.
  - Set and clear of the same register at the same edge: set wins, pending stays 1.
- Busy/stall outputs:
  - rs1_busy/rs2_busy are combinational from pending; no forwarding of the in-flight write.
  - issue_stall is combinational. The issuing stage does not assert sb_set while issue_stall==1; if it does, the set still takes effect.
- Reset mid-operation: scoreboard clear and pipeline flush occur at the same edge. Requesters re-present after reset.

Test Plan:
- Reset: hold rst=0 two cycles with req0_valid=1 -> rf_write_enable=0, req0_ready=0, rs1_busy=0 for all rs1. Release -> first grant is req0.
- Single write: sb_set rd=5, then req0 rd=5 data=0xDEADBEEF -> req0_ready same cycle; next cycle rf_write_enable=1, reg=5, data=0xDEADBEEF; rs1=5 busy until that commit edge, 0 after.
- Contention, FIXED_PRIO=0: both valid continuously, rd 3/4 -> grants alternate req0, req1, req0, ...; exactly one ready per cycle. FIXED_PRIO=1 -> req1 starves while req0 valid.
- x0: req1 rd=0 data=0x1234 -> req1_ready=1, following cycle rf_write_enable=0. sb_set rd=0 -> rs2=0 never busy.
- Set/clear collision: commit to rd=7 on the same edge as sb_set rd=7 -> pending[7] remains 1, issue_stall=1 when sb_rd=7.
- Reset mid-flight: grant at edge N, rst=0 sampled at edge N+1 -> rf_write_enable=0 in cycle N+2 and all pending bits 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 32x32 register file: grants one of two requesters per cycle,
// registers the winning write onto the single RF write port, and tracks pending writes.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,

  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,

  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              issue_stall
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_t;

  grant_t              last_grant;
  grant_t              last_grant_next;
  logic                grant0;
  logic                grant1;
  logic [ADDR_W-1:0]   win_rd;
  logic [DATA_W-1:0]   win_data;
  logic                win_write;

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // Arbitration: grants are suppressed while reset is asserted.
  always_comb begin
    grant0          = 1'b0;
    grant1          = 1'b0;
    last_grant_next = last_grant;
    if (rst) begin
      if (req0_valid && req1_valid) begin
        if (FIXED_PRIO || (last_grant == GRANT_REQ1)) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
    if (grant0) begin
      last_grant_next = GRANT_REQ0;
    end else if (grant1) begin
      last_grant_next = GRANT_REQ1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign win_rd    = grant1 ? req1_rd   : req0_rd;
  assign win_data  = grant1 ? req1_data : req0_data;
  // x0 writes are accepted but never reach the register file.
  assign win_write = (grant0 || grant1) && (win_rd != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant      <= GRANT_REQ1;
      rf_write_enable <= 1'b0;
      rf_write_reg    <= '0;
      rf_write_data   <= '0;
    end else begin
      last_grant      <= last_grant_next;
      rf_write_enable <= win_write;
      if (win_write) begin
        rf_write_reg  <= win_rd;
        rf_write_data <= win_data;
      end
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (sb_set && (sb_rd != '0)) begin
      set_mask[sb_rd] = 1'b1;
    end
    if (rf_write_enable) begin
      clr_mask[rf_write_reg] = 1'b1;
    end
  end

  // Set is applied after clear so a same-edge set of the committing register wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  assign rs1_busy    = (rs1 != '0) && pending[rs1];
  assign rs2_busy    = (rs2 != '0) && pending[rs2];
  assign issue_stall = rs1_busy || rs2_busy || ((sb_rd != '0) && pending[sb_rd]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a reference model predicts grants, busy bits and
// register-file writes; a separate monitor pops expected writes as the DUT presents them.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_rd, req1_rd;
  logic [31:0] req0_data, req1_data;
  logic        sb_set;
  logic [4:0]  sb_rd, rs1, rs2;

  logic        req0_ready, req1_ready;
  logic        rf_write_enable;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        rs1_busy, rs2_busy, issue_stall;

  logic        fp_req0_ready, fp_req1_ready;
  logic        fp_rf_write_enable;
  logic [4:0]  fp_rf_write_reg;
  logic [31:0] fp_rf_write_data;
  logic        fp_rs1_busy, fp_rs2_busy, fp_issue_stall;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
    .rf_write_enable(rf_write_enable), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .sb_set(sb_set), .sb_rd(sb_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .issue_stall(issue_stall)
  );

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
    .rf_write_enable(fp_rf_write_enable), .rf_write_reg(fp_rf_write_reg),
    .rf_write_data(fp_rf_write_data),
    .sb_set(sb_set), .sb_rd(sb_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(fp_rs1_busy), .rs2_busy(fp_rs2_busy), .issue_stall(fp_issue_stall)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  bit [31:0]   m_pend = '0;
  bit          m_last_req1 = 1'b1;
  bit          m_infl_v = 1'b0;
  logic [4:0]  m_infl_rd = '0;
  bit          g0, g1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented write must match the oldest expected one, in the expected cycle.
  always @(negedge clk) begin
    if (rf_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, rf_write_reg}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_cycle", cyc, e.c);
        check("write_reg", {27'd0, rf_write_reg}, {27'd0, e.rd});
        check("write_data", rf_write_data, e.data);
      end
    end else if (exp_q.size() != 0 && exp_q[0].c <= cyc) begin
      wr_t e;
      e = exp_q.pop_front();
      check("missing_write_enable", {31'd0, rf_write_enable}, 32'd1);
    end
  end

  function automatic bit pend_of(input logic [4:0] r);
    return (r != 5'd0) && m_pend[r];
  endfunction

  // One clock cycle: check combinational outputs at the negedge, predict, advance the model.
  task automatic step();
    bit f0, f1;
    @(negedge clk);
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst) begin
      if (req0_valid && req1_valid) begin
        if (m_last_req1) g0 = 1'b1;
        else             g1 = 1'b1;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
    f0 = rst && req0_valid;
    f1 = rst && req1_valid && !req0_valid;
    check("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    check("fp_req0_ready", {31'd0, fp_req0_ready}, {31'd0, f0});
    check("fp_req1_ready", {31'd0, fp_req1_ready}, {31'd0, f1});
    check("rs1_busy", {31'd0, rs1_busy}, {31'd0, pend_of(rs1)});
    check("rs2_busy", {31'd0, rs2_busy}, {31'd0, pend_of(rs2)});
    check("issue_stall", {31'd0, issue_stall},
          {31'd0, pend_of(rs1) | pend_of(rs2) | pend_of(sb_rd)});
    if (g0 && req0_rd != 5'd0) exp_q.push_back('{cyc + 1, req0_rd, req0_data});
    if (g1 && req1_rd != 5'd0) exp_q.push_back('{cyc + 1, req1_rd, req1_data});
    if (!rst) begin
      m_pend      = '0;
      m_last_req1 = 1'b1;
      m_infl_v    = 1'b0;
    end else begin
      if (m_infl_v) m_pend[m_infl_rd] = 1'b0;
      if (sb_set && sb_rd != 5'd0) m_pend[sb_rd] = 1'b1;
      if (g0) m_last_req1 = 1'b0;
      else if (g1) m_last_req1 = 1'b1;
      m_infl_v  = (g0 && req0_rd != 5'd0) || (g1 && req1_rd != 5'd0);
      m_infl_rd = g0 ? req0_rd : req1_rd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_busy_all();
    logic [4:0] s1, s2;
    s1 = rs1;
    s2 = rs2;
    for (int r = 0; r < 32; r++) begin
      rs1 = 5'(r);
      rs2 = 5'(31 - r);
      #1;
      check("sweep_rs1_busy", {31'd0, rs1_busy}, {31'd0, pend_of(rs1)});
      check("sweep_rs2_busy", {31'd0, rs2_busy}, {31'd0, pend_of(rs2)});
    end
    rs1 = s1;
    rs2 = s2;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd9;  req0_data = 32'h0000_0011;
    req1_valid = 1'b0; req1_rd = 5'd10; req1_data = 32'h0000_0022;
    sb_set = 1'b0; sb_rd = '0; rs1 = '0; rs2 = '0;
    @(posedge clk);
    #1;

    // Reset held with a request pending
    step();
    step();
    check_busy_all();
    check("reset_write_reg", {27'd0, rf_write_reg}, 32'd0);
    check("reset_write_data", rf_write_data, 32'd0);

    // First contention after reset goes to req0
    rst = 1'b1;
    req1_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b0;

    // Single write with scoreboard tracking
    sb_set = 1'b1; sb_rd = 5'd5; rs1 = 5'd5;
    step();
    sb_set = 1'b0; sb_rd = 5'd0;
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEAD_BEEF;
    step();
    req0_valid = 1'b0;
    step();
    step();

    // Continuous contention
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = $urandom;
    req1_valid = 1'b1; req1_rd = 5'd4; req1_data = $urandom;
    repeat (6) begin
      step();
      if (g0) req0_data = $urandom;
      if (g1) req1_data = $urandom;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // x0 write and x0 scoreboard set
    req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h0000_1234;
    sb_set = 1'b1; sb_rd = 5'd0; rs2 = 5'd0;
    step();
    req1_valid = 1'b0; sb_set = 1'b0;
    step();
    step();

    // Set and clear of the same register on one edge
    sb_set = 1'b1; sb_rd = 5'd7;
    step();
    sb_set = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'hCAFE_0007;
    step();
    req0_valid = 1'b0;
    sb_set = 1'b1; sb_rd = 5'd7;
    step();
    sb_set = 1'b0; sb_rd = 5'd7; rs1 = 5'd7;
    step();
    check("collision_stall", {31'd0, issue_stall}, 32'd1);

    // Reset one edge after a grant
    req0_valid = 1'b1; req0_rd = 5'd12; req0_data = 32'h1200_0012;
    sb_set = 1'b1; sb_rd = 5'd12; rs1 = 5'd12;
    step();
    req0_valid = 1'b0; sb_set = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("flush_write_enable", {31'd0, rf_write_enable}, 32'd0);
    check_busy_all();

    // Randomised traffic; requesters hold their request until granted
    for (int i = 0; i < 2000; i++) begin
      if (!req0_valid || g0) begin
        req0_valid = ($urandom % 3) != 0;
        req0_rd    = 5'($urandom_range(0, 7));
        req0_data  = $urandom;
      end
      if (!req1_valid || g1) begin
        req1_valid = ($urandom % 3) != 0;
        req1_rd    = 5'($urandom_range(0, 7));
        req1_data  = $urandom;
      end
      sb_set = $urandom_range(0, 1) == 1;
      sb_rd  = 5'($urandom_range(0, 9));
      rs1    = 5'($urandom_range(0, 9));
      rs2    = 5'($urandom_range(0, 9));
      rst    = ($urandom % 100) != 0;
      step();
    end

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; sb_set = 1'b0;
    repeat (4) step();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
